// File: rtl/arp_rx_if.sv
// rtl/arp_rx_if.sv - byte stream and frame status from the MAC frame decoder
interface arp_rx_if;
  logic [7:0] rxd;
  logic       rx_dv;
  logic       arp_decode_valid;
  logic       crc_err;

  modport master (output rxd, output rx_dv, output arp_decode_valid, output crc_err);
  modport slave  (input  rxd, input  rx_dv, input  arp_decode_valid, input  crc_err);
endinterface

// File: rtl/arp_rx.sv
// rtl/arp_rx.sv - ARP body parser: field checks, TPA match, FCS verdict, drop count
module arp_rx #(
  parameter logic [31:0] IP_ADDR = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  arp_rx_if.slave      rx,
  output logic         arp_valid,
  output logic [15:0]  arp_oper,
  output logic [47:0]  arp_sha,
  output logic [31:0]  arp_spa,
  output logic         busy,
  output logic [15:0]  arp_drop_cnt
);

  typedef enum logic [2:0] {IDLE, HDR, TAIL, CHECK, DROP, DROP_CNT} state_t;

  state_t      state;
  logic [4:0]  idx;
  logic        adv_d;
  logic [15:0] oper_sh;
  logic [47:0] sha_sh;
  logic [31:0] spa_sh;
  logic [15:0] drop_cnt;
  logic [4:0]  chk_idx;
  logic        byte_ok;

  assign arp_drop_cnt = drop_cnt;
  // Byte 0 is checked while still in IDLE, before idx has advanced.
  assign chk_idx = (state == IDLE) ? 5'd0 : idx;

  always_comb begin
    byte_ok = 1'b1;
    case (chk_idx)
      5'd0:  byte_ok = (rx.rxd == 8'h00);
      5'd1:  byte_ok = (rx.rxd == 8'h01);
      5'd2:  byte_ok = (rx.rxd == 8'h08);
      5'd3:  byte_ok = (rx.rxd == 8'h00);
      5'd4:  byte_ok = (rx.rxd == 8'h06);
      5'd5:  byte_ok = (rx.rxd == 8'h04);
      5'd6:  byte_ok = (rx.rxd == 8'h00);
      5'd7:  byte_ok = (rx.rxd == 8'h01) || (rx.rxd == 8'h02);
      5'd24: byte_ok = (rx.rxd == IP_ADDR[31:24]);
      5'd25: byte_ok = (rx.rxd == IP_ADDR[23:16]);
      5'd26: byte_ok = (rx.rxd == IP_ADDR[15:8]);
      5'd27: byte_ok = (rx.rxd == IP_ADDR[7:0]);
      default: byte_ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 5'd0;
      adv_d     <= 1'b1;
      oper_sh   <= 16'h0;
      sha_sh    <= 48'h0;
      spa_sh    <= 32'h0;
      drop_cnt  <= 16'h0;
      arp_valid <= 1'b0;
      arp_oper  <= 16'h0;
      arp_sha   <= 48'h0;
      arp_spa   <= 32'h0;
      busy      <= 1'b0;
    end else begin
      adv_d     <= rx.arp_decode_valid;
      arp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rx.arp_decode_valid && !adv_d) begin
            idx   <= 5'd1;
            busy  <= 1'b1;
            state <= byte_ok ? HDR : DROP;
          end
        end
        HDR: begin
          if (!rx.rx_dv) begin
            state <= DROP_CNT;
          end else if (rx.arp_decode_valid) begin
            idx <= idx + 5'd1;
            if (idx == 5'd6 || idx == 5'd7)
              oper_sh <= {oper_sh[7:0], rx.rxd};
            if (idx >= 5'd8 && idx <= 5'd13)
              sha_sh <= {sha_sh[39:0], rx.rxd};
            if (idx >= 5'd14 && idx <= 5'd17)
              spa_sh <= {spa_sh[23:0], rx.rxd};
            if (!byte_ok)
              state <= DROP;
            else if (idx == 5'd27)
              state <= TAIL;
          end
        end
        TAIL: begin
          if (!rx.rx_dv)
            state <= CHECK;
        end
        CHECK: begin
          if (rx.crc_err) begin
            state <= DROP_CNT;
          end else begin
            arp_valid <= 1'b1;
            arp_oper  <= oper_sh;
            arp_sha   <= sha_sh;
            arp_spa   <= spa_sh;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        DROP: begin
          if (!rx.rx_dv)
            state <= DROP_CNT;
        end
        DROP_CNT: begin
          if (drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
